// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
//   Shared definitions for the UART transmit scheduler and its helpers:
//   scheduler state encoding, frame width, and a counter-width helper.
package uart_tx_sched_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {
      SCH_IDLE      = 3'd0,
      SCH_LAUNCH    = 3'd1,
      SCH_WAIT_BUSY = 3'd2,
      SCH_WAIT_DONE = 3'd3,
      SCH_GAP       = 3'd4
   } sch_state_e;

   // Bits needed to count 0..max_val, never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Searches upward from ptr_i+1 with
//   wrap-around and returns the first requesting index.
//   Ports:
//     req_i   - request vector
//     ptr_i   - index of the most recent winner (lowest priority now)
//     en_i    - arbitration enable; no grant when low
//     grant_o - one-hot grant (all zero when nothing wins)
//     idx_o   - encoded index of the winner (0 when nothing wins)
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   input  logic                 en_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int W = $clog2(N);

   logic [W-1:0] cand;
   logic         found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 1; k <= N; k++) begin
         cand = W'((int'(ptr_i) + k) % N);
         if (en_i && !found && req_i[cand]) begin
            found          = 1'b1;
            idx_o          = cand;
            grant_o[cand]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares one UART Tx FSM between NUM_REQ byte requesters. Grants one
//   requester at a time, pulses the Tx FSM send input, follows its bussy
//   output through the frame, then inserts an inter-frame gap.
//
//   state         | meaning
//   --------------+-------------------------------------------------------
//   SCH_IDLE      | waiting for tx_ena, bussy low and a request
//   SCH_LAUNCH    | winner latched; raise tx_send next cycle
//   SCH_WAIT_BUSY | waiting for bussy to rise, timeout counter running
//   SCH_WAIT_DONE | frame on the line, waiting for bussy to fall
//   SCH_GAP       | inter-frame gap, active still high
//
//   Ports:
//     clk, rst_n     - system clock, async active-low reset
//     ena_i          - global enable, registered onto tx_ena_o
//     req_i          - per-requester level requests
//     req_data_i     - requester i byte on [8i+7:8i]
//     ack_o / err_o  - one-cycle completion / abandon pulses
//     grant_id_o     - current or most recent winner
//     active_o       - high from grant until gap ends
//     tx_ena_o, tx_send_o, tx_data_o, tx_bussy_i - Tx FSM interface
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 16,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena_i,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [UART_DATA_W*NUM_REQ-1:0] req_data_i,
   output logic [NUM_REQ-1:0]             ack_o,
   output logic [NUM_REQ-1:0]             err_o,
   output logic [2:0]                     grant_id_o,
   output logic                           active_o,
   output logic                           tx_ena_o,
   output logic                           tx_send_o,
   output logic [UART_DATA_W-1:0]         tx_data_o,
   input  logic                           tx_bussy_i
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = cnt_width(BUSY_TIMEOUT);
   localparam int GW = cnt_width(GAP_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   // With no gap a finished frame returns straight to IDLE.
   localparam sch_state_e POST_STATE = (GAP_CYCLES > 0) ? SCH_GAP : SCH_IDLE;

   sch_state_e             state_q, state_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic [NUM_REQ-1:0]     err_q, err_d;
   logic                   active_q, active_d;
   logic                   send_q, send_d;
   logic [UART_DATA_W-1:0] data_q, data_d;
   logic [2:0]             gid_q, gid_d;
   logic                   tx_ena_q;

   logic [NUM_REQ-1:0]     arb_grant;
   logic [IW-1:0]          arb_idx;
   logic                   arb_en;
   logic                   arb_valid;
   logic                   tmo_hit;
   logic                   gap_hit;

   // bussy also covers the Tx FSM HOLD state, so no grant until it clears.
   assign arb_en    = (state_q == SCH_IDLE) && tx_ena_q && ena_i && !tx_bussy_i;
   assign arb_valid = |arb_grant;
   assign tmo_hit   = (tmo_q == TMO_LAST);
   assign gap_hit   = (gap_q == GAP_LAST);

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .en_i    (arb_en),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SCH_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= IW'(NUM_REQ - 1);
         tmo_q    <= '0;
         gap_q    <= '0;
         ack_q    <= '0;
         err_q    <= '0;
         active_q <= 1'b0;
         send_q   <= 1'b0;
         data_q   <= '0;
         gid_q    <= '0;
         tx_ena_q <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         tmo_q    <= tmo_d;
         gap_q    <= gap_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         active_q <= active_d;
         send_q   <= send_d;
         data_q   <= data_d;
         gid_q    <= gid_d;
         tx_ena_q <= ena_i;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SCH_IDLE: begin
            if (arb_valid) state_d = SCH_LAUNCH;
         end
         SCH_LAUNCH: begin
            state_d = ena_i ? SCH_WAIT_BUSY : SCH_IDLE;
         end
         SCH_WAIT_BUSY: begin
            if (!ena_i)          state_d = SCH_IDLE;
            else if (tx_bussy_i) state_d = SCH_WAIT_DONE;
            else if (tmo_hit)    state_d = POST_STATE;
         end
         SCH_WAIT_DONE: begin
            if (!ena_i)           state_d = SCH_IDLE;
            else if (!tx_bussy_i) state_d = POST_STATE;
         end
         SCH_GAP: begin
            if (!ena_i || gap_hit) state_d = SCH_IDLE;
         end
         default: state_d = SCH_IDLE;
      endcase
   end

   // ptr_q always holds the current winner once granted, so it indexes
   // the ack/err pulse; on abort it stays put so that requester goes last.
   always_comb begin
      ptr_d    = ptr_q;
      tmo_d    = tmo_q;
      gap_d    = gap_q;
      data_d   = data_q;
      gid_d    = gid_q;
      ack_d    = '0;
      err_d    = '0;
      send_d   = 1'b0;
      active_d = active_q;
      case (state_q)
         SCH_IDLE: begin
            if (arb_valid) begin
               ptr_d    = arb_idx;
               gid_d    = 3'(arb_idx);
               data_d   = req_data_i[arb_idx*UART_DATA_W +: UART_DATA_W];
               tmo_d    = '0;
               active_d = 1'b1;
            end
         end
         SCH_LAUNCH: begin
            if (!ena_i) begin
               err_d[ptr_q] = 1'b1;
               active_d     = 1'b0;
            end else begin
               send_d = 1'b1;
            end
         end
         SCH_WAIT_BUSY: begin
            if (!ena_i) begin
               err_d[ptr_q] = 1'b1;
               active_d     = 1'b0;
            end else if (!tx_bussy_i) begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_hit) begin
                  err_d[ptr_q] = 1'b1;
                  gap_d        = '0;
                  active_d     = (POST_STATE != SCH_IDLE);
               end
            end
         end
         SCH_WAIT_DONE: begin
            if (!ena_i) begin
               err_d[ptr_q] = 1'b1;
               active_d     = 1'b0;
            end else if (!tx_bussy_i) begin
               ack_d[ptr_q] = 1'b1;
               gap_d        = '0;
               active_d     = (POST_STATE != SCH_IDLE);
            end
         end
         SCH_GAP: begin
            if (!ena_i || gap_hit) active_d = 1'b0;
            else                   gap_d    = gap_q + 1'b1;
         end
         default: active_d = 1'b0;
      endcase
   end

   assign ack_o      = ack_q;
   assign err_o      = err_q;
   assign grant_id_o = gid_q;
   assign active_o   = active_q;
   assign tx_ena_o   = tx_ena_q;
   assign tx_send_o  = send_q;
   assign tx_data_o  = data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched with a simple Tx FSM bussy model:
//   bussy rises two cycles after a send edge and stays high model_len cycles.
module tb_uart_tx_sched;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack_o;
   logic [3:0]  err_o;
   logic [2:0]  grant_id_o;
   logic        active_o;
   logic        tx_ena_o;
   logic        tx_send_o;
   logic [7:0]  tx_data_o;
   logic        tx_bussy;

   logic        model_bussy;
   logic        hold_bussy;
   logic        model_en;
   logic        send_prev;
   int          model_len;
   int          dly_cnt;
   int          busy_cnt;

   int          checks;
   int          errors;
   logic [3:0]  ack_acc;
   logic [3:0]  err_acc;
   int          n;
   int          exp_id;

   assign tx_bussy = model_bussy | hold_bussy;

   uart_tx_sched #(
      .NUM_REQ      (4),
      .BUSY_TIMEOUT (16),
      .GAP_CYCLES   (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena_i      (ena),
      .req_i      (req),
      .req_data_i (req_data),
      .ack_o      (ack_o),
      .err_o      (err_o),
      .grant_id_o (grant_id_o),
      .active_o   (active_o),
      .tx_ena_o   (tx_ena_o),
      .tx_send_o  (tx_send_o),
      .tx_data_o  (tx_data_o),
      .tx_bussy_i (tx_bussy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tx FSM bussy model
   initial begin
      model_bussy = 1'b0;
      send_prev   = 1'b0;
      dly_cnt     = 0;
      busy_cnt    = 0;
      forever begin
         @(negedge clk);
         if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) model_bussy = 1'b0;
         end
         if (dly_cnt > 0) begin
            dly_cnt = dly_cnt - 1;
            if (dly_cnt == 0) begin
               model_bussy = 1'b1;
               busy_cnt    = model_len;
            end
         end
         if (model_en && tx_send_o && !send_prev) dly_cnt = 2;
         send_prev = tx_send_o;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic probe(input int sel);
      case (sel)
         0:       return active_o;
         1:       return tx_send_o;
         2:       return |ack_o;
         3:       return |err_o;
         4:       return tx_bussy;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_on(input int sel, input logic lvl, input string tag, output int cnt);
      cnt = 0;
      while (probe(sel) !== lvl && cnt < 200) begin
         tick();
         cnt++;
         ack_acc = ack_acc | ack_o;
         err_acc = err_acc | err_o;
      end
      chk(tag, 32'(cnt < 200), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      ack_acc    = '0;
      err_acc    = '0;
      rst_n      = 1'b0;
      ena        = 1'b0;
      req        = '0;
      req_data   = 32'h433221A5;
      hold_bussy = 1'b0;
      model_en   = 1'b1;
      model_len  = 10;

      repeat (3) tick();
      chk("rst_ack",    ack_o, 0);
      chk("rst_err",    err_o, 0);
      chk("rst_active", active_o, 0);
      chk("rst_send",   tx_send_o, 0);
      chk("rst_data",   tx_data_o, 0);
      chk("rst_gid",    grant_id_o, 0);
      chk("rst_txena",  tx_ena_o, 0);
      rst_n = 1'b1;
      tick();

      // single request
      ena = 1'b1;
      req = 4'b0001;
      wait_on(0, 1'b1, "t1_grant_to", n);
      chk("t1_grant_lat", n, 2);
      chk("t1_data", tx_data_o, 8'hA5);
      chk("t1_gid", grant_id_o, 0);
      chk("t1_send_pre", tx_send_o, 0);
      tick();
      chk("t1_send_hi", tx_send_o, 1);
      tick();
      chk("t1_send_lo", tx_send_o, 0);
      wait_on(2, 1'b1, "t1_ack_to", n);
      chk("t1_ack_lat", n, 12);
      chk("t1_ack", ack_o, 4'b0001);
      chk("t1_err", err_o, 0);
      chk("t1_data_hold", tx_data_o, 8'hA5);
      req = 4'b0000;
      tick();
      chk("t1_ack_once", ack_o, 0);
      chk("t1_gap_active", active_o, 1);
      tick();
      chk("t1_gap_end", active_o, 0);

      // contention, from a fresh pointer
      do_reset();
      req_data = 32'h43322110;
      req      = 4'b1111;
      ack_acc  = '0;
      err_acc  = '0;
      for (int i = 0; i < 5; i++) begin
         exp_id = i % 4;
         wait_on(0, 1'b1, "t2_grant_to", n);
         chk("t2_gid", grant_id_o, exp_id);
         chk("t2_data", tx_data_o, 32'h10 + 32'h11 * exp_id);
         wait_on(2, 1'b1, "t2_ack_to", n);
         chk("t2_ack", ack_o, 32'd1 << exp_id);
         if (i == 4) begin
            req      = 4'b0100;
            model_en = 1'b0;
         end
         wait_on(0, 1'b0, "t2_gap_to", n);
      end
      chk("t2_no_err", err_acc, 0);

      // busy timeout on requester 2
      ack_acc = '0;
      wait_on(1, 1'b1, "t3_send_to", n);
      chk("t3_gid", grant_id_o, 2);
      wait_on(3, 1'b1, "t3_err_to", n);
      chk("t3_err_lat", n, 16);
      chk("t3_err", err_o, 4'b0100);
      chk("t3_no_ack", ack_acc, 0);
      req      = 4'b0010;
      model_en = 1'b1;
      tick();
      chk("t3_err_once", err_o, 0);
      wait_on(1, 1'b1, "t3_next_to", n);
      chk("t3_next_gid", grant_id_o, 1);
      chk("t3_next_data", tx_data_o, 8'h21);
      wait_on(2, 1'b1, "t3_next_ack_to", n);
      chk("t3_next_ack", ack_o, 4'b0010);
      req = 4'b0000;
      wait_on(0, 1'b0, "t3_gap_to", n);

      // HOLD gating: bussy high while ena comes back
      ena = 1'b0;
      tick();
      tick();
      chk("t4_txena_off", tx_ena_o, 0);
      hold_bussy = 1'b1;
      ena        = 1'b1;
      req        = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_held", {active_o, tx_send_o}, 0);
      end
      hold_bussy = 1'b0;
      tick();
      chk("t4_grant", active_o, 1);
      chk("t4_gid", grant_id_o, 1);
      tick();
      chk("t4_send", tx_send_o, 1);
      wait_on(2, 1'b1, "t4_ack_to", n);
      chk("t4_ack", ack_o, 4'b0010);
      req = 4'b0000;
      wait_on(0, 1'b0, "t4_gap_to", n);

      // abort while requester 3 is in WAIT_DONE
      req = 4'b1000;
      wait_on(0, 1'b1, "t5_grant_to", n);
      chk("t5_gid", grant_id_o, 3);
      wait_on(4, 1'b1, "t5_bussy_to", n);
      tick();
      tick();
      ena = 1'b0;
      tick();
      chk("t5_err", err_o, 4'b1000);
      chk("t5_ack", ack_o, 0);
      chk("t5_send", tx_send_o, 0);
      chk("t5_txena", tx_ena_o, 0);
      chk("t5_active", active_o, 0);
      ena = 1'b1;
      req = 4'b1001;
      tick();
      chk("t5_err_once", err_o, 0);
      wait_on(0, 1'b1, "t5_regrant_to", n);
      chk("t5_regrant_gid", grant_id_o, 0);
      chk("t5_regrant_data", tx_data_o, 8'h10);
      wait_on(2, 1'b1, "t5_ack_to", n);
      chk("t5_ack0", ack_o, 4'b0001);
      req = 4'b1000;
      wait_on(0, 1'b0, "t5_gap_to", n);

      // async reset in WAIT_DONE
      wait_on(0, 1'b1, "t6_grant_to", n);
      chk("t6_gid", grant_id_o, 3);
      wait_on(4, 1'b1, "t6_bussy_to", n);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_active", active_o, 0);
      chk("t6_rst_data", tx_data_o, 0);
      chk("t6_rst_gid", grant_id_o, 0);
      chk("t6_rst_send", tx_send_o, 0);
      chk("t6_rst_txena", tx_ena_o, 0);
      tick();
      rst_n = 1'b1;
      wait_on(0, 1'b1, "t6_first_to", n);
      chk("t6_first_gid", grant_id_o, 3);
      req = 4'b1001;
      wait_on(2, 1'b1, "t6_ack_to", n);
      chk("t6_ack", ack_o, 4'b1000);
      wait_on(0, 1'b0, "t6_gap_to", n);
      wait_on(0, 1'b1, "t6_next_to", n);
      chk("t6_next_gid", grant_id_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter FSM between NUM_REQ byte requesters. It sits between the client logic and the Tx FSM, and drives the Tx FSM's ena, send and data inputs. It watches the Tx FSM's bussy output to sequence exactly one frame at a time, inserts a programmable inter-frame gap, and acknowledges each requester when its byte has left the line.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
BUSY_TIMEOUT, 16, clk cycles allowed between the send edge and bussy rising before the frame is abandoned.
GAP_CYCLES, 2, idle clk cycles inserted after bussy falls before the next grant (0 allowed).

Ports:
clk  input  1  single system clock; also clocks the Tx FSM.
rst_n  input  1  asynchronous, active-low reset.
ena  input  1  global enable; passed through to the Tx FSM and gates all scheduling.
req  input  NUM_REQ  per-requester level request; held until ack or err.
req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
ack  output  NUM_REQ  one-cycle pulse: requester i's frame completed.
err  output  NUM_REQ  one-cycle pulse: requester i's frame abandoned (timeout or ena drop).
grant_id  output  3  index of the currently or most recently served requester.
active  output  1  high from grant until the gap ends.
tx_ena  output  1  to Tx FSM ena.
tx_send  output  1  to Tx FSM send; the rising edge starts a frame.
tx_data  output  8  to Tx FSM data; stable from grant until bussy falls.
tx_bussy  input  1  from Tx FSM bussy.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; ack, err, tx_send, active = 0; tx_data=0; grant_id=0; RR pointer=NUM_REQ-1, so requester 0 wins first; counters=0.
- tx_ena is a registered copy of ena, giving 1 cycle latency.
- IDLE: the block grants only when tx_ena=1, tx_bussy=0 and req != 0. The Tx FSM reports bussy=1 in its HOLD state, so this check also waits out HOLD.
- Arbitration: round-robin, searching from pointer+1 upward with wrap-around.
- On grant: tx_data <= req_data[winner]; grant_id <= winner; pointer <= winner; active=1; state goes to LAUNCH.
- LAUNCH: tx_send=1 for exactly 1 cycle, then goes to WAIT_BUSY.
- WAIT_BUSY: tx_send=0; the counter increments each cycle.
  - tx_bussy=1 -> WAIT_DONE.
  - counter reaches BUSY_TIMEOUT -> err[grant_id] pulse, then GAP.
- WAIT_DONE: hold tx_data. When tx_bussy falls (1->0), pulse ack[grant_id] for 1 cycle, then GAP.
- GAP: count GAP_CYCLES cycles, then IDLE with active=0. When GAP_CYCLES=0, go straight to IDLE.
- Grant-to-send latency is 1 cycle. The earliest back-to-back re-grant is GAP_CYCLES+1 cycles after ack.
- ack and err are mutually exclusive, and at most one bit of each is set in any cycle.
- req deasserting after grant is ignored: the latched byte is still sent and acked. A requester that keeps req high after ack is treated as a new request.
- ena falling while in LAUNCH, WAIT_BUSY or WAIT_DONE:
  - pulse err[grant_id] and drop tx_send;
  - go to IDLE with active=0;
  - pointer stays at the aborted winner, so that requester is re-arbitrated last.
- ena falling in IDLE or GAP: return to or stay in IDLE; no pulses.
- Widths: the timeout counter is clog2(BUSY_TIMEOUT+1) bits; the gap counter is clog2(GAP_CYCLES+1) bits, minimum 1 bit.

Decomposition:
- A shared UART package holds:
  - state encoding constants SCH_IDLE=0, SCH_LAUNCH=1, SCH_WAIT_BUSY=2, SCH_WAIT_DONE=3, SCH_GAP=4;
  - the frame width constant UART_DATA_W=8.
- One sub-module, rr_arbiter (parameter N). Inputs: req vector, pointer, enable. Outputs: one-hot grant and encoded index. It is purely combinational and reused by future Rx and DMA schedulers.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5, bussy model rises 2 cycles after send and is held 10 cycles -> tx_data=8'hA5, tx_send high 1 cycle 1 cycle after grant, ack[0] pulses once on the bussy fall, active drops after 2 gap cycles.
- Contention: req=4'b1111 held and re-raised after each ack, data 8'h10/8'h21/8'h32/8'h43 -> grant order 0,1,2,3,0; no err.
- Timeout: req[2]=1, bussy stuck at 0 -> err=4'b0100 exactly 16 cycles after the tx_send edge, ack stays 0, the scheduler returns to IDLE and grants the next request.
- HOLD gating: ena rises with req[1]=1 and the bussy model high for 1 cycle (HOLD) -> no tx_send until bussy=0; then a normal frame and ack[1].
- Abort: ena drops mid-WAIT_DONE while serving requester 3 -> err[3] pulse, tx_send=0, tx_ena=0 next cycle; after ena returns with req=4'b1001, requester 0 wins.
- Reset mid-frame: rst_n low in WAIT_DONE -> all outputs 0 immediately (asynchronous); after release with req=4'b1000, the first grant goes to 3 and the next contention winner is 0.
